// File: rtl/complex_divider_seq_if.sv
// Operand/result handshake bundle for complex_divider_seq; master drives operands, slave returns quotients.
`default_nettype none

interface complex_divider_seq_if #(
  parameter int W     = 8,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     a_real;
  logic signed [W-1:0]     a_imag;
  logic signed [W-1:0]     b_real;
  logic signed [W-1:0]     b_imag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] result_real;
  logic signed [OUT_W-1:0] result_imag;
  logic                    out_sat;
  logic                    out_dbz;

  modport master (
    output in_valid, a_real, a_imag, b_real, b_imag, out_ready,
    input  in_ready, out_valid, result_real, result_imag, out_sat, out_dbz
  );

  modport slave (
    input  in_valid, a_real, a_imag, b_real, b_imag, out_ready,
    output in_ready, out_valid, result_real, result_imag, out_sat, out_dbz
  );
endinterface

`default_nettype wire

// File: rtl/complex_divider_seq.sv
// ============================================================================
// complex_divider_seq : sequential fixed-point complex divide q = a / b
//   CDIV_ROUND_EN adds a guard-bit iteration for round-half-away-from-zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module complex_divider_seq #(
  parameter int W     = 8,
  parameter int FRAC  = 8,
  parameter int OUT_W = 16
) (
  input wire logic           clk,
  input wire logic           rst_n,
  complex_divider_seq_if.slave bus
);

  localparam int NUM_W = 2*W + 1;
  localparam int DEN_W = 2*W;
  localparam int DVD_W = NUM_W + FRAC;
`ifdef CDIV_ROUND_EN
  localparam int RND   = 1;
`else
  localparam int RND   = 0;
`endif
  localparam int QW    = DVD_W + RND;
  localparam int CNT_W = $clog2(QW);
  localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                  state;
  logic signed [W-1:0]     op_ar, op_ai, op_br, op_bi;
  logic [DEN_W-1:0]        den;
  logic [QW-1:0]           dvd_re, dvd_im, quo_re, quo_im;
  logic [DEN_W-1:0]        rem_re, rem_im;
  logic [CNT_W-1:0]        cnt;
  logic                    neg_re, neg_im, zero_re, zero_im, dbz;
  logic                    in_ready, out_valid, out_sat, out_dbz;
  logic [OUT_W-1:0]        res_re, res_im;

  logic signed [NUM_W-1:0] ar_x, ai_x, br_x, bi_x, num_re, num_im, sq;
  logic [NUM_W-1:0]        mag_re, mag_im;
  logic [DEN_W:0]          step_re, step_im;
  logic [OUT_W:0]          fin_re, fin_im;

  // One restoring step: returns {quotient bit, next remainder}.
  function automatic logic [DEN_W:0] div_step(input logic [DEN_W-1:0] rem,
                                              input logic msb,
                                              input logic [DEN_W-1:0] d);
    logic [DEN_W:0] trial;
    logic           ge;
    trial = {rem, msb};
    ge    = trial >= {1'b0, d};
    return {ge, ge ? (trial[DEN_W-1:0] - d) : trial[DEN_W-1:0]};
  endfunction

  // Returns {sat, result} from quotient magnitude, sign and divide-by-zero state.
  function automatic logic [OUT_W:0] finish(input logic [QW-1:0] q, input logic neg,
                                            input logic zero, input logic dz);
    logic [QW:0]      m;
    logic [OUT_W-1:0] r;
    logic             s;
`ifdef CDIV_ROUND_EN
    m = ({1'b0, q} + {{QW{1'b0}}, 1'b1}) >> 1;
`else
    m = {1'b0, q};
`endif
    s = 1'b0;
    if (dz) begin
      r = zero ? '0 : (neg ? -MAX_OUT : MAX_OUT);
    end else if (m > {{(QW+1-OUT_W){1'b0}}, MAX_OUT}) begin
      s = 1'b1;
      r = neg ? -MAX_OUT : MAX_OUT;
    end else begin
      r = neg ? -m[OUT_W-1:0] : m[OUT_W-1:0];
    end
    return {s, r};
  endfunction

  assign ar_x   = NUM_W'(op_ar);
  assign ai_x   = NUM_W'(op_ai);
  assign br_x   = NUM_W'(op_br);
  assign bi_x   = NUM_W'(op_bi);
  assign num_re = ar_x*br_x + ai_x*bi_x;
  assign num_im = ai_x*br_x - ar_x*bi_x;
  assign sq     = br_x*br_x + bi_x*bi_x;
  assign mag_re = num_re[NUM_W-1] ? -num_re : num_re;
  assign mag_im = num_im[NUM_W-1] ? -num_im : num_im;

  assign step_re = div_step(rem_re, dvd_re[QW-1], den);
  assign step_im = div_step(rem_im, dvd_im[QW-1], den);
  assign fin_re  = finish(quo_re, neg_re, zero_re, dbz);
  assign fin_im  = finish(quo_im, neg_im, zero_im, dbz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_ar     <= '0;
      op_ai     <= '0;
      op_br     <= '0;
      op_bi     <= '0;
      den       <= '0;
      dvd_re    <= '0;
      dvd_im    <= '0;
      quo_re    <= '0;
      quo_im    <= '0;
      rem_re    <= '0;
      rem_im    <= '0;
      cnt       <= '0;
      neg_re    <= 1'b0;
      neg_im    <= 1'b0;
      zero_re   <= 1'b0;
      zero_im   <= 1'b0;
      dbz       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out_dbz   <= 1'b0;
      res_re    <= '0;
      res_im    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (bus.in_valid && in_ready) begin
            op_ar    <= bus.a_real;
            op_ai    <= bus.a_imag;
            op_br    <= bus.b_real;
            op_bi    <= bus.b_imag;
            in_ready <= 1'b0;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          den     <= sq[DEN_W-1:0];
          dbz     <= (sq == '0);
          // With b == 0 the product a*conj(b) is zero, so the forced sign comes from a itself.
          neg_re  <= (sq == '0) ? op_ar[W-1] : num_re[NUM_W-1];
          neg_im  <= (sq == '0) ? op_ai[W-1] : num_im[NUM_W-1];
          zero_re <= (op_ar == '0);
          zero_im <= (op_ai == '0);
          dvd_re  <= {mag_re, {(FRAC+RND){1'b0}}};
          dvd_im  <= {mag_im, {(FRAC+RND){1'b0}}};
          rem_re  <= '0;
          rem_im  <= '0;
          quo_re  <= '0;
          quo_im  <= '0;
          cnt     <= CNT_W'(QW-1);
          state   <= S_DIV;
        end
        S_DIV: begin
          quo_re <= {quo_re[QW-2:0], step_re[DEN_W]};
          quo_im <= {quo_im[QW-2:0], step_im[DEN_W]};
          rem_re <= step_re[DEN_W-1:0];
          rem_im <= step_im[DEN_W-1:0];
          dvd_re <= dvd_re << 1;
          dvd_im <= dvd_im << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) state <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid) begin
            res_re    <= fin_re[OUT_W-1:0];
            res_im    <= fin_im[OUT_W-1:0];
            out_sat   <= fin_re[OUT_W] | fin_im[OUT_W];
            out_dbz   <= dbz;
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.result_real = res_re;
  assign bus.result_imag = res_im;
  assign bus.out_sat     = out_sat;
  assign bus.out_dbz     = out_dbz;

endmodule

`default_nettype wire

// File: tb/tb_complex_divider_seq.sv
// Scoreboard bench for complex_divider_seq: directed vectors, latency, hold, and mid-operation reset.
`default_nettype none

module tb_complex_divider_seq;

`ifdef CDIV_ROUND_EN
  localparam int LAT = 28;
  localparam logic [15:0] T5_RE = 16'h00AB;
`else
  localparam int LAT = 27;
  localparam logic [15:0] T5_RE = 16'h00AA;
`endif

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sat;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  complex_divider_seq_if #(.W(8), .OUT_W(16)) bus ();

  complex_divider_seq #(.W(8), .FRAC(8), .OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_real", bus.result_real, e.re);
        chk("result_imag", bus.result_imag, e.im);
        chk("out_sat", {15'd0, bus.out_sat}, {15'd0, e.sat});
        chk("out_dbz", {15'd0, bus.out_dbz}, {15'd0, e.dbz});
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge where out_valid drops.
  task automatic run_op(input logic signed [7:0] ar, input logic signed [7:0] ai,
                        input logic signed [7:0] br, input logic signed [7:0] bi,
                        input logic [15:0] er, input logic [15:0] ei,
                        input logic es, input logic ed, input bit hold);
    int   cyc;
    logic [15:0] keep_re, keep_im;
    bus.a_real = ar; bus.a_imag = ai; bus.b_real = br; bus.b_imag = bi;
    bus.in_valid = 1'b1;
    bus.out_ready = !hold;
    chk("in_ready_before_accept", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk);
    sb.push_back('{re: er, im: ei, sat: es, dbz: ed});
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", 16'(cyc), 16'(LAT));
    if (hold) begin
      keep_re = bus.result_real;
      keep_im = bus.result_imag;
      for (int i = 0; i < 10; i++) begin
        bus.a_real = 8'sd7; bus.a_imag = 8'sd1; bus.b_real = 8'sd1; bus.b_imag = 8'sd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
        chk("hold_real", bus.result_real, keep_re);
        chk("hold_imag", bus.result_imag, keep_im);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    cyc = 0;
    while (bus.out_valid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("handshake_drop", {15'd0, bus.out_valid}, 16'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_real = '0; bus.a_imag = '0; bus.b_real = '0; bus.b_imag = '0;
    #1;
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_real", bus.result_real, 16'd0);
    chk("rst_flags", {14'd0, bus.out_sat, bus.out_dbz}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_op( 8'sd4,    8'sd0,  8'sd2,  8'sd0, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op( 8'sd1,    8'sd1,  8'sd1, -8'sd1, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op(-8'sd128,  8'sd0,  8'sd0,  8'sd1, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    run_op( 8'sd5,   -8'sd3,  8'sd0,  8'sd0, 16'h7FFF, 16'h8001, 1'b0, 1'b1, 1'b0);
    run_op( 8'sd0,    8'sd7,  8'sd0,  8'sd0, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op( 8'sd2,    8'sd0,  8'sd3,  8'sd0, T5_RE,    16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(-8'sd3,    8'sd0,  8'sd2,  8'sd0, 16'hFE80, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op( 8'sd1,    8'sd0,  8'sd0,  8'sd3, 16'h0000, 16'hFFAB, 1'b0, 1'b0, 1'b0);

    // Abort an operation part-way through the divide phase.
    bus.a_real = 8'sd4; bus.a_imag = 8'sd0; bus.b_real = 8'sd2; bus.b_imag = 8'sd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("abort_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("abort_real", bus.result_real, 16'd0);
    chk("abort_imag", bus.result_imag, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    run_op(-8'sd3, 8'sd0, 8'sd2, 8'sd0, 16'hFE80, 16'h0000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
